// File: rtl/fv_req_arbiter_pkg.sv
// Shared widths and types for the feature-value request arbiter.
// The FIFO word layout is the write-side format of the FV info FIFO.
package fv_req_arbiter_pkg;

    localparam int NUM_PE     = 4;
    localparam int FV_ADDR_W  = 8;
    localparam int TAG_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int MAX_FV_NUM = 256;
    localparam int NUM_FV_W   = $clog2(MAX_FV_NUM) + 1;

    // Word pushed into the FV info FIFO; valid doubles as the push strobe.
    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] FV_addr;
        logic [TAG_W-1:0]     PE_tag;
    } fv_info2fv_fifo_t;

    // One held request per Edge PE.
    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] FV_addr;
    } fv_req_pe_t;

endpackage

// File: rtl/fv_req_arbiter_if.sv
// Request/FIFO-write bundle between the Edge PEs, the arbiter and the FV FIFO.
// Num_FV and addr_err exist only when FV_REQ_ADDR_CHECK_EN is defined.
// slave: the arbiter side; master: the PE/FIFO environment side.
interface fv_req_arbiter_if;
    import fv_req_arbiter_pkg::*;

    logic [NUM_PE-1:0]                req_valid;
    logic [NUM_PE-1:0][FV_ADDR_W-1:0] req_FV_addr;
    logic [NUM_PE-1:0]                req_ready;
    logic                             wfull;
    fv_info2fv_fifo_t                 wdata;
`ifdef FV_REQ_ADDR_CHECK_EN
    logic [NUM_FV_W-1:0]              Num_FV;
    logic [NUM_PE-1:0]                addr_err;
`endif

    modport slave (
        input  req_valid, req_FV_addr, wfull,
`ifdef FV_REQ_ADDR_CHECK_EN
        input  Num_FV,
        output addr_err,
`endif
        output req_ready, wdata
    );

    modport master (
        output req_valid, req_FV_addr, wfull,
`ifdef FV_REQ_ADDR_CHECK_EN
        output Num_FV,
        input  addr_err,
`endif
        input  req_ready, wdata
    );

endinterface

// File: rtl/fv_rr_arbiter.sv
// Rotating-priority grant: the scan starts at r_rr_ptr and the pointer moves
// to one past the winner whenever the caller consumes the grant (i_advance).
module fv_rr_arbiter
    import fv_req_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PE-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_PE-1:0] o_grant_onehot,
    output logic [TAG_W-1:0]  o_grant_idx,
    output logic              o_any
);

    logic [TAG_W-1:0] r_rr_ptr;
    logic [TAG_W-1:0] w_scan;

    // Pick the first requester at or after r_rr_ptr, wrapping modulo NUM_PE.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_scan      = '0;
        // Walk from farthest to nearest so the nearest requester is written last and wins.
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            w_scan = TAG_W'((int'(r_rr_ptr) + k) % NUM_PE);
            if (i_req[w_scan]) begin
                o_grant_idx = w_scan;
                o_any       = 1'b1;
            end
        end
        o_grant_onehot = o_any ? (NUM_PE'(1) << o_grant_idx) : '0;
    end

    // Pointer advances past the consumed winner; holds otherwise.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (i_advance) begin
            r_rr_ptr <= (o_grant_idx == TAG_W'(NUM_PE - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fv_req_arbiter.sv
// Collects one pending FV read request per Edge PE and round-robins them
// into the FV info FIFO write port, tagging each push with its PE index.
// Optional build macro: FV_REQ_ADDR_CHECK_EN drops requests with
// FV_addr >= Num_FV and pulses addr_err for the offending PE instead.
module fv_req_arbiter
    import fv_req_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    fv_req_arbiter_if.slave bus
);

    fv_req_pe_t [NUM_PE-1:0] r_pend;
    logic [NUM_PE-1:0]       w_pending;
    logic [NUM_PE-1:0]       w_grant_onehot;
    logic [TAG_W-1:0]        w_grant_idx;
    logic                    w_any;
    logic                    w_push;
    logic [NUM_PE-1:0]       w_accept;
    logic [NUM_PE-1:0]       w_store;

    // Flatten the per-PE valid bits for the arbiter.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_pending[i] = r_pend[i].valid;
        end
    end

    fv_rr_arbiter u_rr (
        .clk            (clk),
        .reset          (reset),
        .i_req          (w_pending),
        .i_advance      (w_push),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx),
        .o_any          (w_any)
    );

    // Reset masks the push so a request held into the reset cycle never leaks out.
    assign w_push = w_any & ~bus.wfull & ~reset;

    // A PE may issue when its slot is empty or is being drained this cycle.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            bus.req_ready[i] = ~reset & (~r_pend[i].valid | (w_push & w_grant_onehot[i]));
        end
    end

    assign w_accept = bus.req_valid & bus.req_ready;

`ifdef FV_REQ_ADDR_CHECK_EN
    logic [NUM_PE-1:0] w_in_range;
    logic [NUM_PE-1:0] r_addr_err;

    // Address is usable only below the number of loaded feature values.
    always_comb begin
        w_in_range = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_in_range[i] = 32'(bus.req_FV_addr[i]) < 32'(bus.Num_FV);
        end
    end

    assign w_store = w_accept & w_in_range;

    // One-cycle error pulse for each accepted-but-dropped request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= '0;
        end else begin
            r_addr_err <= w_accept & ~w_in_range;
        end
    end

    assign bus.addr_err = r_addr_err & {NUM_PE{~reset}};
`else
    assign w_store = w_accept;
`endif

    // Per-PE slot: a new request overrides a same-cycle drain of that slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (w_store[i]) begin
                    r_pend[i].valid   <= 1'b1;
                    r_pend[i].FV_addr <= bus.req_FV_addr[i];
                end else if (w_push & w_grant_onehot[i]) begin
                    r_pend[i].valid   <= 1'b0;
                end
            end
        end
    end

    // FIFO word is all zero when nothing is pushed, never stale.
    always_comb begin
        bus.wdata = '0;
        if (w_push) begin
            bus.wdata.valid   = 1'b1;
            bus.wdata.FV_addr = r_pend[w_grant_idx].FV_addr;
            bus.wdata.PE_tag  = w_grant_idx;
        end
    end

endmodule

// File: tb/tb_fv_req_arbiter.sv
// Bench for fv_req_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a reference model of pending PEs and the
// last-served PE. Build with FV_REQ_ADDR_CHECK_EN to cover address checking.
module tb_fv_req_arbiter;
    import fv_req_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    fv_req_arbiter_if bus ();

    fv_req_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: which PEs hold a request, their addresses, who was served last.
    bit                   m_pend [NUM_PE];
    logic [FV_ADDR_W-1:0] m_addr [NUM_PE];
    int                   m_last;
    logic [NUM_PE-1:0]    m_err;

    fv_info2fv_fifo_t     trace [$];
    logic [NUM_PE-1:0]    err_trace [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_PE; i++) begin
            m_pend[i] = 1'b0;
            m_addr[i] = '0;
        end
        m_last = NUM_PE - 1;
        m_err  = '0;
    endtask

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic cycle();
        int                g;
        int                pe;
        bit                push;
        bit                keep;
        logic [NUM_PE-1:0] exp_ready;
        logic [NUM_PE-1:0] exp_err;
        fv_info2fv_fifo_t  exp_w;

        @(negedge clk);
        // The next PE to serve is the pending one closest after the last served.
        g = -1;
        for (int d = 1; d <= NUM_PE; d++) begin
            pe = (m_last + d) % NUM_PE;
            if (g < 0 && m_pend[pe]) g = pe;
        end
        push  = !reset && (g >= 0) && !bus.wfull;
        exp_w = '0;
        if (push) begin
            exp_w.valid   = 1'b1;
            exp_w.FV_addr = m_addr[g];
            exp_w.PE_tag  = TAG_W'(g);
        end
        for (int i = 0; i < NUM_PE; i++) begin
            exp_ready[i] = !reset && (!m_pend[i] || (push && g == i));
        end
        exp_err = reset ? '0 : m_err;

        check("wdata", bus.wdata, exp_w);
        check("req_ready", bus.req_ready, exp_ready);
`ifdef FV_REQ_ADDR_CHECK_EN
        check("addr_err", bus.addr_err, exp_err);
        err_trace.push_back(bus.addr_err);
`endif
        trace.push_back(bus.wdata);

        if (reset) begin
            model_reset();
        end else begin
            if (push) begin
                m_pend[g] = 1'b0;
                m_last    = g;
            end
            m_err = '0;
            for (int i = 0; i < NUM_PE; i++) begin
                if (bus.req_valid[i] && exp_ready[i]) begin
                    keep = 1'b1;
`ifdef FV_REQ_ADDR_CHECK_EN
                    keep = (32'(bus.req_FV_addr[i]) < 32'(bus.Num_FV));
`endif
                    if (keep) begin
                        m_pend[i] = 1'b1;
                        m_addr[i] = bus.req_FV_addr[i];
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        reset           = 1'b1;
        bus.req_valid   = '0;
        bus.req_FV_addr = '0;
        bus.wfull       = 1'b0;
`ifdef FV_REQ_ADDR_CHECK_EN
        bus.Num_FV      = NUM_FV_W'(256);
`endif
        cycle();
        cycle();
        check("reset_ready", bus.req_ready, 4'h0);
        reset = 1'b0;

        // Single request from PE2 appears one cycle later, exactly once.
        trace.delete();
        bus.req_valid      = 4'b0100;
        bus.req_FV_addr[2] = 8'h15;
        cycle();
        bus.req_valid = '0;
        cycle();
        cycle();
        check("p1_idle_accept", trace[0], 11'h0);
        check("p1_push", trace[1], {1'b1, 8'h15, 2'd2});
        check("p1_once", trace[2], 11'h0);

        // PE3 next: pointer sits at 3, and serving it wraps the pointer to 0.
        trace.delete();
        bus.req_valid      = 4'b1000;
        bus.req_FV_addr[3] = 8'h33;
        cycle();
        bus.req_valid = '0;
        cycle();
        check("p1b_push_pe3", trace[1], {1'b1, 8'h33, 2'd3});

        // All four at once: back-to-back pushes in order 0..3.
        trace.delete();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NUM_PE; i++) bus.req_FV_addr[i] = FV_ADDR_W'(8'h10 + i);
        cycle();
        bus.req_valid = '0;
        for (int k = 0; k < 5; k++) cycle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("p2_push%0d", k), trace[k+1], {1'b1, 8'(8'h10 + k), 2'(k)});
        end
        check("p2_drained", trace[5], 11'h0);

        // Back-pressure holds PE1 for five cycles, then it goes out immediately.
        trace.delete();
        bus.wfull          = 1'b1;
        bus.req_valid      = 4'b0010;
        bus.req_FV_addr[1] = 8'h21;
        cycle();
        bus.req_valid = '0;
        for (int k = 0; k < 5; k++) cycle();
        check("p3_ready_blocked", bus.req_ready[1], 1'b0);
        bus.wfull = 1'b0;
        cycle();
        for (int k = 1; k <= 5; k++) check($sformatf("p3_hold%0d", k), trace[k], 11'h0);
        check("p3_release", trace[6], {1'b1, 8'h21, 2'd1});

        // PE0 streams while PE3 asks once: PE3 first, then PE0 every cycle.
        trace.delete();
        bus.req_FV_addr[3] = 8'h3f;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid      = (k == 0) ? 4'b1001 : 4'b0001;
            bus.req_FV_addr[0] = FV_ADDR_W'(8'h40 + k);
            cycle();
        end
        bus.req_valid = '0;
        cycle();
        check("p4_pe3", trace[1], {1'b1, 8'h3f, 2'd3});
        check("p4_pe0_a", trace[2], {1'b1, 8'h40, 2'd0});
        check("p4_pe0_b", trace[3], {1'b1, 8'h42, 2'd0});
        check("p4_pe0_c", trace[4], {1'b1, 8'h43, 2'd0});
        check("p4_pe0_d", trace[5], {1'b1, 8'h44, 2'd0});
        check("p4_pe0_e", trace[6], {1'b1, 8'h45, 2'd0});

        // Reset with PEs 0, 1, 3 pending drops everything.
        bus.wfull          = 1'b1;
        bus.req_valid      = 4'b1011;
        bus.req_FV_addr[0] = 8'h50;
        bus.req_FV_addr[1] = 8'h51;
        bus.req_FV_addr[3] = 8'h53;
        cycle();
        bus.req_valid = '0;
        cycle();
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        bus.wfull = 1'b0;
        trace.delete();
        cycle();
        cycle();
        check("p5_no_push0", trace[0], 11'h0);
        check("p5_no_push1", trace[1], 11'h0);
        check("p5_ready", bus.req_ready, 4'hF);

`ifdef FV_REQ_ADDR_CHECK_EN
        // Out-of-range request is dropped with an error pulse; in-range one goes through.
        trace.delete();
        err_trace.delete();
        bus.Num_FV         = NUM_FV_W'(4);
        bus.req_valid      = 4'b0001;
        bus.req_FV_addr[0] = 8'h05;
        cycle();
        bus.req_valid = '0;
        cycle();
        cycle();
        bus.req_valid      = 4'b0001;
        bus.req_FV_addr[0] = 8'h03;
        cycle();
        bus.req_valid = '0;
        cycle();
        check("p6_err_pulse", err_trace[1], 4'b0001);
        check("p6_err_once", err_trace[2], 4'b0000);
        check("p6_dropped", trace[1], 11'h0);
        check("p6_push", trace[4], {1'b1, 8'h03, 2'd0});
`endif

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            reset         = ($urandom_range(63) == 0);
            bus.wfull     = ($urandom_range(3) == 0);
            bus.req_valid = NUM_PE'($urandom);
            for (int i = 0; i < NUM_PE; i++) bus.req_FV_addr[i] = FV_ADDR_W'($urandom);
`ifdef FV_REQ_ADDR_CHECK_EN
            bus.Num_FV = NUM_FV_W'($urandom_range(300));
`endif
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
